out_stream_serializer: RTL and testbench

//  Downstream of the output switch: merges the 1280-bit G stream and 256-bit H stream onto one
//  256-bit AXI-Stream master toward the output DMA. Each G beat is split into RATIO 256-bit slices,
//  LSB slice first. Arbitration is per packet (tlast-bounded) and round-robin; a tdest bit tags the

---
 rtl/out_stream_serializer.sv | 181 ++++++++++++++++++
 tb/tb_out_stream_serializer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_stream_serializer.sv
// out_stream_serializer: merges a wide G stream and a narrow H stream onto one
// DATA_W AXI-Stream master. Each G beat is emitted as RATIO slices, LSB slice first.
// Arbitration is per packet and round-robin, and tdest tags the source.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_axis_g_*                      G slave (DATA_W*RATIO payload, valid/ready/last)
//   s_axis_h_*                      H slave (DATA_W payload, valid/ready/last)
//   s_weight_switch                 H sideband, captured with each accepted H beat
//   m_axis_*                        merged master (data/valid/ready/last/dest)
//   m_weight_switch                 sideband of the H beat being sent, 0 for G beats
module out_stream_serializer #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned RATIO  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W*RATIO-1:0] s_axis_g_tdata,
    input  logic                    s_axis_g_tvalid,
    output logic                    s_axis_g_tready,
    input  logic                    s_axis_g_tlast,
    input  logic [DATA_W-1:0]       s_axis_h_tdata,
    input  logic                    s_axis_h_tvalid,
    output logic                    s_axis_h_tready,
    input  logic                    s_axis_h_tlast,
    input  logic                    s_weight_switch,
    output logic [DATA_W-1:0]       m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tdest,
    output logic                    m_weight_switch
);
    localparam int unsigned      CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
    localparam logic             GRANT_G  = 1'b0;
    localparam logic             GRANT_H  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_G_SEND = 2'd1,
        ST_H_SEND = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [RATIO-1:0][DATA_W-1:0] gbuf_q, gbuf_d;
    logic                         glast_q, glast_d;
    logic                         gfull_q, gfull_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [DATA_W-1:0]            hbuf_q, hbuf_d;
    logic                         hlast_q, hlast_d;
    logic                         hws_q, hws_d;
    logic                         hfull_q, hfull_d;
    logic                         last_grant_q, last_grant_d;

    logic m_hs, g_acc, h_acc, g_wrap, h_pop;

    assign m_hs   = m_axis_tvalid && m_axis_tready;
    assign g_acc  = s_axis_g_tvalid && s_axis_g_tready;
    assign h_acc  = s_axis_h_tvalid && s_axis_h_tready;
    assign g_wrap = (state_q == ST_G_SEND) && m_hs && (cnt_q == CNT_LAST);
    assign h_pop  = (state_q == ST_H_SEND) && m_hs;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the IDLE decision looks at tvalid only, packets end on a sent tlast
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_axis_h_tvalid && (last_grant_q == GRANT_G || !s_axis_g_tvalid)) begin
                    state_d = ST_H_SEND;
                end else if (s_axis_g_tvalid) begin
                    state_d = ST_G_SEND;
                end
            end
            ST_G_SEND: if (g_wrap && glast_q) state_d = ST_IDLE;
            ST_H_SEND: if (h_pop && hlast_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs: only the granted source sees ready; a buffered tlast blocks further accepts
    always_comb begin
        s_axis_g_tready = 1'b0;
        s_axis_h_tready = 1'b0;
        m_axis_tvalid   = 1'b0;
        m_axis_tdata    = '0;
        m_axis_tlast    = 1'b0;
        m_axis_tdest    = 1'b0;
        m_weight_switch = 1'b0;
        case (state_q)
            ST_G_SEND: begin
                s_axis_g_tready = !(gfull_q && glast_q)
                                  && (!gfull_q || (m_axis_tready && cnt_q == CNT_LAST));
                m_axis_tvalid   = gfull_q;
                m_axis_tdata    = gbuf_q[cnt_q];
                m_axis_tlast    = glast_q && (cnt_q == CNT_LAST);
            end
            ST_H_SEND: begin
                s_axis_h_tready = !(hfull_q && hlast_q) && (!hfull_q || m_axis_tready);
                m_axis_tvalid   = hfull_q;
                m_axis_tdata    = hbuf_q;
                m_axis_tlast    = hlast_q;
                m_axis_tdest    = 1'b1;
                m_weight_switch = hws_q;
            end
            default: ;
        endcase
    end

    // Buffer next-state: drain on the last slice/beat, reload if a new beat arrives alongside
    always_comb begin
        gbuf_d       = gbuf_q;
        glast_d      = glast_q;
        gfull_d      = gfull_q;
        cnt_d        = cnt_q;
        hbuf_d       = hbuf_q;
        hlast_d      = hlast_q;
        hws_d        = hws_q;
        hfull_d      = hfull_q;
        last_grant_d = last_grant_q;

        if ((state_q == ST_G_SEND) && m_hs) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                gfull_d = 1'b0;
                if (glast_q) last_grant_d = GRANT_G;
            end
        end
        if (g_acc) begin
            gbuf_d  = s_axis_g_tdata;
            glast_d = s_axis_g_tlast;
            gfull_d = 1'b1;
        end

        if (h_pop) begin
            hfull_d = 1'b0;
            if (hlast_q) last_grant_d = GRANT_H;
        end
        if (h_acc) begin
            hbuf_d  = s_axis_h_tdata;
            hlast_d = s_axis_h_tlast;
            hws_d   = s_weight_switch;
            hfull_d = 1'b1;
        end
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gbuf_q       <= '0;
            glast_q      <= 1'b0;
            gfull_q      <= 1'b0;
            cnt_q        <= '0;
            hbuf_q       <= '0;
            hlast_q      <= 1'b0;
            hws_q        <= 1'b0;
            hfull_q      <= 1'b0;
            last_grant_q <= GRANT_G;
        end else begin
            gbuf_q       <= gbuf_d;
            glast_q      <= glast_d;
            gfull_q      <= gfull_d;
            cnt_q        <= cnt_d;
            hbuf_q       <= hbuf_d;
            hlast_q      <= hlast_d;
            hws_q        <= hws_d;
            hfull_q      <= hfull_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_out_stream_serializer.sv
// Bench for out_stream_serializer: queue-driven G/H sources, a packet-level
// round-robin model producing the expected output stream, and a negedge monitor.
module tb_out_stream_serializer;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned RATIO  = 5;
    localparam int unsigned G_W    = DATA_W * RATIO;

    logic              clk, rst_n;
    logic [G_W-1:0]    s_axis_g_tdata;
    logic              s_axis_g_tvalid, s_axis_g_tready, s_axis_g_tlast;
    logic [DATA_W-1:0] s_axis_h_tdata;
    logic              s_axis_h_tvalid, s_axis_h_tready, s_axis_h_tlast;
    logic              s_weight_switch;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tdest;
    logic              m_weight_switch;

    out_stream_serializer #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_g_tdata(s_axis_g_tdata), .s_axis_g_tvalid(s_axis_g_tvalid),
        .s_axis_g_tready(s_axis_g_tready), .s_axis_g_tlast(s_axis_g_tlast),
        .s_axis_h_tdata(s_axis_h_tdata), .s_axis_h_tvalid(s_axis_h_tvalid),
        .s_axis_h_tready(s_axis_h_tready), .s_axis_h_tlast(s_axis_h_tlast),
        .s_weight_switch(s_weight_switch),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdest(m_axis_tdest), .m_weight_switch(m_weight_switch)
    );

    typedef struct {logic [G_W-1:0] data; logic last;} gbeat_t;
    typedef struct {logic [DATA_W-1:0] data; logic last; logic ws;} hbeat_t;
    typedef struct {logic [DATA_W-1:0] data; logic last; logic dest; logic ws;} obeat_t;

    gbeat_t gq[$], mg[$];     // driver queue / model pending list for G
    hbeat_t hq[$], mh[$];     // same for H
    obeat_t exp_q[$], log_q[$];

    int   vectors = 0;
    int   miscompares = 0;
    logic model_lg;           // last granted source in the model: 0 = G, 1 = H
    int   rdy_mode;           // 0: ready high, 1: toggle, 2: ready low

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // G packet: slice s of beat b is base+16*b+s, or random when rnd is set
    task automatic add_g_pkt(input int nbeats, input int base, input bit rnd);
        gbeat_t gb;
        logic [DATA_W-1:0] sl;
        for (int b = 0; b < nbeats; b++) begin
            for (int s = 0; s < int'(RATIO); s++) begin
                if (rnd) begin
                    for (int w = 0; w < int'(DATA_W / 32); w++) sl[w*32 +: 32] = $urandom();
                end else begin
                    sl = DATA_W'(base + 16 * b + s);
                end
                gb.data[s*DATA_W +: DATA_W] = sl;
            end
            gb.last = (b == nbeats - 1);
            gq.push_back(gb);
            mg.push_back(gb);
        end
    endtask

    // H packet with random payload; beat b carries ws_pat[b]
    task automatic add_h_pkt(input int nbeats, input logic [7:0] ws_pat);
        hbeat_t hb;
        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w < int'(DATA_W / 32); w++) hb.data[w*32 +: 32] = $urandom();
            hb.ws   = ws_pat[b];
            hb.last = (b == nbeats - 1);
            hq.push_back(hb);
            mh.push_back(hb);
        end
    endtask

    // Packet-level round robin over everything pending: whole packets, G split into slices
    task automatic model_run();
        gbeat_t gb;
        hbeat_t hb;
        obeat_t ob;
        bit     done;
        while (mg.size() > 0 || mh.size() > 0) begin
            done = 1'b0;
            if (mh.size() > 0 && (model_lg == 1'b0 || mg.size() == 0)) begin
                while (!done && mh.size() > 0) begin
                    hb = mh.pop_front();
                    ob.data = hb.data; ob.last = hb.last; ob.dest = 1'b1; ob.ws = hb.ws;
                    exp_q.push_back(ob);
                    done = hb.last;
                end
                model_lg = 1'b1;
            end else begin
                while (!done && mg.size() > 0) begin
                    gb = mg.pop_front();
                    for (int s = 0; s < int'(RATIO); s++) begin
                        ob.data = gb.data[s*DATA_W +: DATA_W];
                        ob.last = gb.last && (s == int'(RATIO) - 1);
                        ob.dest = 1'b0;
                        ob.ws   = 1'b0;
                        exp_q.push_back(ob);
                    end
                    done = gb.last;
                end
                model_lg = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n = 0;
        while ((exp_q.size() > 0 || gq.size() > 0 || hq.size() > 0) && n < max_cyc) begin
            @(negedge clk); #2;
            n++;
        end
        chki({name, " beats left after cycle budget"}, exp_q.size() + gq.size() + hq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk1({tag, " m_tvalid"}, m_axis_tvalid, 1'b0);
        chkw({tag, " m_tdata"}, m_axis_tdata, '0);
        chk1({tag, " m_tlast"}, m_axis_tlast, 1'b0);
        chk1({tag, " m_tdest"}, m_axis_tdest, 1'b0);
        chk1({tag, " m_ws"}, m_weight_switch, 1'b0);
        chk1({tag, " g_tready"}, s_axis_g_tready, 1'b0);
        chk1({tag, " h_tready"}, s_axis_h_tready, 1'b0);
    endtask

    // G source: present queue head, pop after a handshake
    initial begin
        bit hs;
        s_axis_g_tvalid = 1'b0; s_axis_g_tdata = '0; s_axis_g_tlast = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_axis_g_tvalid && s_axis_g_tready;
            @(posedge clk); #1;
            if (hs && rst_n && gq.size() > 0) void'(gq.pop_front());
            if (gq.size() > 0) begin
                s_axis_g_tvalid = 1'b1; s_axis_g_tdata = gq[0].data; s_axis_g_tlast = gq[0].last;
            end else begin
                s_axis_g_tvalid = 1'b0;
            end
        end
    end

    // H source
    initial begin
        bit hs;
        s_axis_h_tvalid = 1'b0; s_axis_h_tdata = '0; s_axis_h_tlast = 1'b0; s_weight_switch = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_axis_h_tvalid && s_axis_h_tready;
            @(posedge clk); #1;
            if (hs && rst_n && hq.size() > 0) void'(hq.pop_front());
            if (hq.size() > 0) begin
                s_axis_h_tvalid = 1'b1; s_axis_h_tdata = hq[0].data;
                s_axis_h_tlast = hq[0].last; s_weight_switch = hq[0].ws;
            end else begin
                s_axis_h_tvalid = 1'b0;
            end
        end
    end

    // Sink ready pattern
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: stream contents, hold-while-stalled, no bubbles, ready rules, inter-packet gap
    initial begin
        bit          prev_stall, prev_hs, prev_last, gap_armed, exp_last;
        int unsigned sidx;
        int          gap_idle;
        obeat_t      prev_o, e;
        prev_stall = 0; prev_hs = 0; prev_last = 0; gap_armed = 0; sidx = 0; gap_idle = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0; prev_hs = 0; prev_last = 0; gap_armed = 0; sidx = 0; gap_idle = 0;
            end else begin
                if (prev_stall) begin
                    chk1("stall tvalid held", m_axis_tvalid, 1'b1);
                    chkw("stall tdata held", m_axis_tdata, prev_o.data);
                    chk1("stall tlast held", m_axis_tlast, prev_o.last);
                    chk1("stall tdest held", m_axis_tdest, prev_o.dest);
                    chk1("stall ws held", m_weight_switch, prev_o.ws);
                end
                if (prev_hs && !prev_last) chk1("no bubble in packet", m_axis_tvalid, 1'b1);
                if (m_axis_tvalid) begin
                    exp_last = (exp_q.size() > 0) ? exp_q[0].last : 1'b0;
                    if (!m_axis_tdest) begin
                        chk1("g_tready rule", s_axis_g_tready,
                             m_axis_tready && (sidx == RATIO - 1) && !exp_last);
                        chk1("h_tready while G granted", s_axis_h_tready, 1'b0);
                    end else begin
                        chk1("h_tready rule", s_axis_h_tready, m_axis_tready && !exp_last);
                        chk1("g_tready while H granted", s_axis_g_tready, 1'b0);
                    end
                end
                if (gap_armed) begin
                    if (m_axis_tvalid) begin
                        chki("idle cycles between packets", gap_idle, 1);
                        gap_armed = 0;
                    end else if (!s_axis_g_tready && !s_axis_h_tready) begin
                        gap_idle++;
                    end
                end
                prev_last = m_axis_tlast;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected output beat: got data %h, required no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chkw("beat tdata", m_axis_tdata, e.data);
                        chk1("beat tlast", m_axis_tlast, e.last);
                        chk1("beat tdest", m_axis_tdest, e.dest);
                        chk1("beat ws", m_weight_switch, e.ws);
                        log_q.push_back(e);
                        prev_last = e.last;
                        if (!e.dest) sidx = (sidx + 1) % RATIO;
                        if (e.last && exp_q.size() > 0) begin
                            gap_armed = 1; gap_idle = 0;
                        end
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_hs    = m_axis_tvalid && m_axis_tready;
                prev_o.data = m_axis_tdata; prev_o.last = m_axis_tlast;
                prev_o.dest = m_axis_tdest; prev_o.ws = m_weight_switch;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nlast;
        rst_n = 1'b0; rdy_mode = 0; model_lg = 1'b0;
        #3;
        chk_outs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both sources pending out of reset: H, G, H, G with one idle cycle between
        @(negedge clk);
        log_q.delete();
        add_h_pkt(1, 8'b1); add_h_pkt(1, 8'b0);
        add_g_pkt(1, 'h30, 0); add_g_pkt(1, 'h40, 0);
        model_run();
        wait_drain("rr", 300);
        chki("rr beat count", log_q.size(), 12);
        if (log_q.size() == 12) begin
            chk1("rr pkt0 dest", log_q[0].dest, 1'b1);
            chk1("rr pkt0 ws", log_q[0].ws, 1'b1);
            chkw("rr pkt1 first slice", log_q[1].data, 256'h30);
            chk1("rr pkt1 tlast", log_q[5].last, 1'b1);
            chk1("rr pkt2 dest", log_q[6].dest, 1'b1);
            chkw("rr pkt3 last slice", log_q[11].data, 256'h44);
            chk1("rr pkt3 tlast", log_q[11].last, 1'b1);
        end

        // Two-beat G packet, ready high, with first-beat latency
        @(negedge clk);
        log_q.delete();
        add_g_pkt(2, 'h10, 0);
        model_run();
        n = 0;
        do begin @(negedge clk); n++; end while (!m_axis_tvalid && n < 20);
        chki("g first-beat latency", n, 3);
        wait_drain("g2", 200);
        chki("g2 beat count", log_q.size(), 10);
        if (log_q.size() == 10) begin
            chkw("g2 out0", log_q[0].data, 256'h10);
            chkw("g2 out4", log_q[4].data, 256'h14);
            chkw("g2 out5", log_q[5].data, 256'h20);
            chkw("g2 out9", log_q[9].data, 256'h24);
            nlast = 0;
            foreach (log_q[i]) if (log_q[i].last) nlast++;
            chki("g2 tlast count", nlast, 1);
            chk1("g2 tlast on 10th", log_q[9].last, 1'b1);
        end

        // Three-beat H packet, ws = 1,0,1
        @(negedge clk);
        log_q.delete();
        add_h_pkt(3, 8'b101);
        model_run();
        wait_drain("h3", 200);
        chki("h3 beat count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk1("h3 ws0", log_q[0].ws, 1'b1);
            chk1("h3 ws1", log_q[1].ws, 1'b0);
            chk1("h3 ws2", log_q[2].ws, 1'b1);
            chk1("h3 tlast1", log_q[1].last, 1'b0);
            chk1("h3 tlast2", log_q[2].last, 1'b1);
        end

        // G packet with sink ready toggling every cycle
        @(negedge clk);
        log_q.delete();
        rdy_mode = 1;
        add_g_pkt(2, 'h60, 0);
        model_run();
        wait_drain("toggle", 300);
        rdy_mode = 0;
        chki("toggle beat count", log_q.size(), 10);
        if (log_q.size() == 10) begin
            chkw("toggle out3", log_q[3].data, 256'h63);
            chkw("toggle out7", log_q[7].data, 256'h72);
        end

        // H backpressure for 8 cycles, with a random G beat waiting behind it
        @(negedge clk);
        log_q.delete();
        rdy_mode = 2;
        add_h_pkt(2, 8'b10);
        add_g_pkt(1, 0, 1);
        model_run();
        repeat (8) @(negedge clk);
        chki("bp h beats still queued", hq.size(), 1);
        chk1("bp m_tvalid", m_axis_tvalid, 1'b1);
        chk1("bp m_tdest", m_axis_tdest, 1'b1);
        chk1("bp h_tready", s_axis_h_tready, 1'b0);
        rdy_mode = 0;
        wait_drain("bp", 300);
        chki("bp beat count", log_q.size(), 7);

        // Reset in the middle of a G beat, then H first and G from slice 0 of a new beat
        @(negedge clk);
        log_q.delete();
        add_g_pkt(2, 'h80, 0);
        model_run();
        n = 0;
        while (log_q.size() < 3 && n < 50) begin @(negedge clk); #2; n++; end
        chki("pre-reset slices seen", log_q.size(), 3);
        @(posedge clk); #2;
        chk1("pre-reset m_tvalid", m_axis_tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_outs_zero("mid-packet reset");
        gq.delete(); hq.delete(); mg.delete(); mh.delete(); exp_q.delete();
        model_lg = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        add_h_pkt(1, 8'b1);
        add_g_pkt(1, 'h90, 0);
        model_run();
        wait_drain("post-reset", 300);
        chki("post-reset beat count", log_q.size(), 6);
        if (log_q.size() == 6) begin
            chk1("post-reset first dest", log_q[0].dest, 1'b1);
            chkw("post-reset G slice0", log_q[1].data, 256'h90);
            chkw("post-reset G slice4", log_q[5].data, 256'h94);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
